// File: rtl/python_stream_decoder.sv
// python_stream_decoder
//   Decodes the PYTHON sensor data/sync word stream into a pixel-word stream
//   for the corner-detector pipeline. Training, black-calibration, CRC and
//   inter-frame words are stripped. Line length, row count and sync order
//   are checked, and violations are reported as sticky error flags.
//
// Ports
//   c          clock, all logic on posedge
//   rst        synchronous active-high reset
//   data       32-bit sensor word (4 pixels, byte 0 = leftmost)
//   sync       8-bit sync code qualifying data on the same cycle
//   err_clr    clears the sticky error flags
//   pix_data   registered pixel word (holds its value on dropped words)
//   pix_valid  pix_data carries a pixel word this cycle
//   pix_sof    first word of a frame
//   pix_eol    last word of a line
//   pix_eof    last word of a frame (always together with pix_eol)
//   row_idx    0-based row of the current pix_data word
//   frame_cnt  number of frames whose FE tail word was accepted
//   err_len    sticky: a line did not contain WPL words
//   err_rows   sticky: a frame did not contain ROWS rows
//   err_seq    sticky: sync code not legal in the current state
module python_stream_decoder #(
  parameter int COLS = 16,
  parameter int ROWS = 8
) (
  input  logic        c,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  sync,
  input  logic        err_clr,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [15:0] row_idx,
  output logic [31:0] frame_cnt,
  output logic        err_len,
  output logic        err_rows,
  output logic        err_seq
);

  // Sensor sync code values, shared with the sensor interface definitions.
  localparam logic [7:0] SC_FS = 8'hAA;
  localparam logic [7:0] SC_FE = 8'hCA;
  localparam logic [7:0] SC_LS = 8'h2A;
  localparam logic [7:0] SC_LE = 8'h4A;
  localparam logic [7:0] SC_IM = 8'h0A;
  localparam logic [7:0] SC_BL = 8'h1A;
  localparam logic [7:0] SC_WN = 8'h01;
  localparam logic [7:0] SC_CS = 8'h55;
  localparam logic [7:0] SC_TR = 8'hE9;

  // One extra bit so that wcnt+1 / row+1 never wrap before the compare.
  localparam logic [16:0] WPL_W  = 17'(COLS / 4);
  localparam logic [16:0] ROWS_W = 17'(ROWS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LINE   = 3'd1,
    TAIL_L = 3'd2,
    TAIL_F = 3'd3,
    GAP    = 3'd4
  } state_t;

  // Input capture stage: a word is accepted here and decoded one edge later.
  logic        in_vld_q, in_vld_d;
  logic [31:0] in_data_q, in_data_d;
  logic [7:0]  in_sync_q, in_sync_d;

  state_t      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] row_q, row_d;
  logic [31:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic        pix_sof_q, pix_sof_d;
  logic        pix_eol_q, pix_eol_d;
  logic        pix_eof_q, pix_eof_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic        err_len_q, err_len_d;
  logic        err_rows_q, err_rows_d;
  logic        err_seq_q, err_seq_d;

  logic        set_len, set_rows, set_seq;
  logic        emit;
  logic [15:0] wcnt_inc;
  logic        len_ok, rows_ok;

  // Saturating word count: an over-long line is still flagged at its tail.
  assign wcnt_inc = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
  // The tail word itself is the one not yet counted.
  assign len_ok   = (({1'b0, wcnt_q} + 17'd1) == WPL_W);
  assign rows_ok  = (({1'b0, row_q} + 17'd1) == ROWS_W);

  always_comb begin
    in_vld_d    = 1'b1;
    in_data_d   = data;
    in_sync_d   = sync;
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    row_d       = row_q;
    frame_cnt_d = frame_cnt_q;
    pix_sof_d   = 1'b0;
    pix_eol_d   = 1'b0;
    pix_eof_d   = 1'b0;
    set_len     = 1'b0;
    set_rows    = 1'b0;
    set_seq     = 1'b0;
    emit        = 1'b0;

    if (in_vld_q) begin
      case (state_q)
        IDLE: begin
          // Everything outside a frame (black rows, stray LS/LE, TR) is dropped silently.
          if (in_sync_q == SC_FS) begin
            emit      = 1'b1;
            pix_sof_d = 1'b1;
            row_d     = 16'd0;
            wcnt_d    = 16'd1;
            state_d   = LINE;
          end
        end
        LINE: begin
          case (in_sync_q)
            SC_WN, SC_IM: begin
              emit   = 1'b1;
              wcnt_d = wcnt_inc;
            end
            SC_LE: begin
              emit    = 1'b1;
              wcnt_d  = wcnt_inc;
              state_d = TAIL_L;
            end
            SC_FE: begin
              emit    = 1'b1;
              wcnt_d  = wcnt_inc;
              state_d = TAIL_F;
            end
            SC_FS, SC_LS, SC_BL, SC_CS, SC_TR: begin
              set_seq = 1'b1;
              state_d = IDLE;
            end
            default: begin
              set_seq = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
        TAIL_L: begin
          if (in_sync_q == SC_WN) begin
            emit      = 1'b1;
            pix_eol_d = 1'b1;
            set_len   = !len_ok;
            state_d   = GAP;
          end else begin
            set_seq = 1'b1;
            state_d = IDLE;
          end
        end
        TAIL_F: begin
          if (in_sync_q == SC_WN) begin
            emit        = 1'b1;
            pix_eol_d   = 1'b1;
            pix_eof_d   = 1'b1;
            set_len     = !len_ok;
            set_rows    = !rows_ok;
            frame_cnt_d = frame_cnt_q + 32'd1;
            state_d     = IDLE;
          end else begin
            set_seq = 1'b1;
            state_d = IDLE;
          end
        end
        GAP: begin
          case (in_sync_q)
            SC_CS, SC_TR: state_d = GAP;
            SC_LS: begin
              emit    = 1'b1;
              row_d   = row_q + 16'd1;
              wcnt_d  = 16'd1;
              state_d = LINE;
            end
            SC_FS: begin
              // Frame ended without FE: flag it, then start the new frame.
              set_rows  = 1'b1;
              set_seq   = 1'b1;
              emit      = 1'b1;
              pix_sof_d = 1'b1;
              row_d     = 16'd0;
              wcnt_d    = 16'd1;
              state_d   = LINE;
            end
            default: begin
              set_seq = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end

    pix_valid_d = emit;
    pix_data_d  = emit ? in_data_q : pix_data_q;
    // A new error on the same edge as err_clr wins.
    err_len_d   = set_len  | (err_len_q  & ~err_clr);
    err_rows_d  = set_rows | (err_rows_q & ~err_clr);
    err_seq_d   = set_seq  | (err_seq_q  & ~err_clr);
  end

  always_ff @(posedge c) begin
    if (rst) begin
      in_vld_q    <= 1'b0;
      in_data_q   <= 32'd0;
      in_sync_q   <= 8'd0;
      state_q     <= IDLE;
      wcnt_q      <= 16'd0;
      row_q       <= 16'd0;
      pix_data_q  <= 32'd0;
      pix_valid_q <= 1'b0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      pix_eof_q   <= 1'b0;
      frame_cnt_q <= 32'd0;
      err_len_q   <= 1'b0;
      err_rows_q  <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      in_vld_q    <= in_vld_d;
      in_data_q   <= in_data_d;
      in_sync_q   <= in_sync_d;
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      row_q       <= row_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_sof_q   <= pix_sof_d;
      pix_eol_q   <= pix_eol_d;
      pix_eof_q   <= pix_eof_d;
      frame_cnt_q <= frame_cnt_d;
      err_len_q   <= err_len_d;
      err_rows_q  <= err_rows_d;
      err_seq_q   <= err_seq_d;
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign pix_sof   = pix_sof_q;
  assign pix_eol   = pix_eol_q;
  assign pix_eof   = pix_eof_q;
  assign row_idx   = row_q;
  assign frame_cnt = frame_cnt_q;
  assign err_len   = err_len_q;
  assign err_rows  = err_rows_q;
  assign err_seq   = err_seq_q;

endmodule

// File: tb/tb_python_stream_decoder.sv
// tb_python_stream_decoder
//   Directed frames drive the decoder; every expected pixel word is pushed
//   into a queue when it is sent, and a monitor pops and compares whenever
//   pix_valid is seen. Status outputs are checked at the end of each case.
module tb_python_stream_decoder;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int WPL  = COLS / 4;

  localparam logic [7:0] FS = 8'hAA;
  localparam logic [7:0] FE = 8'hCA;
  localparam logic [7:0] LS = 8'h2A;
  localparam logic [7:0] LE = 8'h4A;
  localparam logic [7:0] IM = 8'h0A;
  localparam logic [7:0] BL = 8'h1A;
  localparam logic [7:0] WN = 8'h01;
  localparam logic [7:0] TR = 8'hE9;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  sync;
  logic        err_clr;
  logic [31:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol, pix_eof;
  logic [15:0] row_idx;
  logic [31:0] frame_cnt;
  logic        err_len, err_rows, err_seq;

  python_stream_decoder #(.COLS(COLS), .ROWS(ROWS)) dut (
    .c(clk), .rst(rst), .data(data), .sync(sync), .err_clr(err_clr),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .row_idx(row_idx),
    .frame_cnt(frame_cnt), .err_len(err_len), .err_rows(err_rows),
    .err_seq(err_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
    logic [15:0] row;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   failed    = 0;
  int   vcount    = 0;

  function automatic logic [31:0] pix_word(input int r, input int w);
    logic [7:0] b;
    b = 8'(r * 16 + w * 4);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic void push(input logic [31:0] d, input logic sof,
                               input logic eol, input logic eof, input int r);
    exp_t e;
    e.d = d; e.sof = sof; e.eol = eol; e.eof = eof; e.row = 16'(r);
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end else begin
      $display("[TB] check %s = %0h ok", name, act);
    end
  endtask

  task automatic send(input logic [7:0] s, input logic [31:0] d);
    @(negedge clk);
    rst = 1'b0; err_clr = 1'b0; sync = s; data = d;
  endtask

  task automatic flush();
    repeat (4) send(TR, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; err_clr = 1'b0; sync = TR; data = 32'h0;
    @(posedge clk); #2;
    exp_q.delete();
    vcount = 0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    rst = 1'b0; err_clr = 1'b1; sync = TR; data = 32'h0;
  endtask

  // One frame of nrows lines. short_row drops the IM word of that row,
  // ls_row injects an LS mid-line, rst_row pulses rst mid-line.
  task automatic send_frame(input int nrows, input int gap, input int short_row,
                            input int ls_row, input int rst_row);
    bit dead;
    logic [7:0]  s;
    logic [31:0] d;
    logic        last;
    dead = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      last = (r == nrows - 1);
      for (int w = 0; w < WPL; w++) begin
        if (r == short_row && w == 1) continue;
        d = pix_word(r, w);
        if (w == 0)            s = (r == 0) ? FS : LS;
        else if (w == WPL - 2) s = last ? FE : LE;
        else if (w == WPL - 1) s = WN;
        else                   s = IM;
        if (!dead) push(d, (r == 0 && w == 0), (w == WPL - 1), (last && w == WPL - 1), r);
        send(s, d);
        if (r == ls_row && w == 1 && !dead) begin
          send(LS, 32'hDEADBEEF);
          dead = 1'b1;
        end
        if (r == rst_row && w == 1 && !dead) begin
          @(negedge clk);
          rst = 1'b1; sync = TR; data = 32'h0;
          @(posedge clk); #2;
          // The word still in the input stage is discarded by the reset.
          exp_q.delete();
          vcount = 0;
          chk("rst_pix_valid", 32'(pix_valid), 32'd0);
          chk("rst_pix_data", pix_data, 32'd0);
          chk("rst_flags", {29'd0, pix_sof, pix_eol, pix_eof}, 32'd0);
          chk("rst_row_idx", 32'(row_idx), 32'd0);
          chk("rst_frame_cnt", frame_cnt, 32'd0);
          chk("rst_errs", {29'd0, err_len, err_rows, err_seq}, 32'd0);
          dead = 1'b1;
        end
      end
      if (!last) repeat (gap) send(TR, $urandom);
    end
    flush();
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (pix_valid === 1'b1) begin
        tests_run++;
        vcount++;
        got.d = pix_data; got.sof = pix_sof; got.eol = pix_eol;
        got.eof = pix_eof; got.row = row_idx;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_word got d=%h sof=%b eol=%b eof=%b row=%0d expected none",
                   pix_data, pix_sof, pix_eol, pix_eof, row_idx);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failed++;
            $display("FAIL pix_word got d=%h sof=%b eol=%b eof=%b row=%0d expected d=%h sof=%b eol=%b eof=%b row=%0d",
                     got.d, got.sof, got.eol, got.eof, got.row, e.d, e.sof, e.eol, e.eof, e.row);
          end else begin
            $display("[TB] word d=%h sof=%b eol=%b eof=%b row=%0d ok",
                     got.d, got.sof, got.eol, got.eof, got.row);
          end
        end
      end else if ((pix_sof | pix_eol | pix_eof) !== 1'b0) begin
        tests_run++;
        failed++;
        $display("FAIL marker_without_valid got sof=%b eol=%b eof=%b expected 0",
                 pix_sof, pix_eol, pix_eof);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, failed + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; err_clr = 1'b0; sync = TR; data = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(pix_valid), 32'd0);
    chk("reset_data", pix_data, 32'd0);
    chk("reset_row_idx", 32'(row_idx), 32'd0);
    chk("reset_frame_cnt", frame_cnt, 32'd0);
    chk("reset_errs", {29'd0, err_len, err_rows, err_seq}, 32'd0);

    // Case 1: 3 black rows, then a clean 16x8 frame with 300 TR per gap.
    vcount = 0;
    for (int b = 0; b < 3; b++) begin
      repeat (WPL) send(BL, $urandom);
      repeat (300) send(TR, $urandom);
    end
    chk("black_rows_no_valid", 32'(vcount), 32'd0);
    send_frame(ROWS, 300, -1, -1, -1);
    chk("f1_valid_words", 32'(vcount), 32'd32);
    chk("f1_frame_cnt", frame_cnt, 32'd1);
    chk("f1_errs", {29'd0, err_len, err_rows, err_seq}, 32'd0);

    // Case 2: two frames separated by 8431 TR words.
    do_reset();
    send_frame(ROWS, 4, -1, -1, -1);
    repeat (8431) send(TR, $urandom);
    send_frame(ROWS, 4, -1, -1, -1);
    chk("f2_frame_cnt", frame_cnt, 32'd2);
    chk("f2_valid_words", 32'(vcount), 32'd64);
    chk("f2_errs", {29'd0, err_len, err_rows, err_seq}, 32'd0);

    // Case 3: row 3 one word short.
    do_reset();
    send_frame(ROWS, 4, 3, -1, -1);
    chk("short_err_len", 32'(err_len), 32'd1);
    chk("short_other_errs", {30'd0, err_rows, err_seq}, 32'd0);
    chk("short_frame_cnt", frame_cnt, 32'd1);
    chk("short_valid_words", 32'(vcount), 32'd31);
    pulse_clr();
    send(TR, 32'h0);
    send(TR, 32'h0);
    chk("err_clr_len", 32'(err_len), 32'd0);

    // Case 4: LS injected mid-line in row 2.
    do_reset();
    send_frame(ROWS, 4, -1, 2, -1);
    chk("ls_err_seq", 32'(err_seq), 32'd1);
    chk("ls_frame_cnt", frame_cnt, 32'd0);
    chk("ls_valid_words", 32'(vcount), 32'd10);

    // Case 5: FE on row 5 (6-row frame).
    do_reset();
    send_frame(6, 4, -1, -1, -1);
    chk("short_frame_err_rows", 32'(err_rows), 32'd1);
    chk("short_frame_cnt", frame_cnt, 32'd1);
    chk("short_frame_other_errs", {30'd0, err_len, err_seq}, 32'd0);

    // Case 6: reset pulse mid-row 4, then a clean frame.
    send_frame(ROWS, 4, -1, -1, 4);
    chk("after_rst_no_valid", 32'(vcount), 32'd0);
    send_frame(ROWS, 4, -1, -1, -1);
    chk("post_rst_frame_cnt", frame_cnt, 32'd1);
    chk("post_rst_valid_words", 32'(vcount), 32'd32);
    chk("post_rst_errs", {29'd0, err_len, err_rows, err_seq}, 32'd0);

    flush();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
